// File: rtl/pet_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : pet_keymatrix
//  Description : PET keyboard matrix emulator. Key events are queued in a
//                small FIFO and applied to an 80-bit (10x8) key matrix,
//                either immediately (live press/release) or as a timed
//                keystroke (press, hold, release, gap) paced by a 1 MHz
//                clock enable. The I/O block reads one row at a time
//                through a registered active-low column port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pet_keymatrix #(
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD_US    = 40000,
    parameter int GAP_US     = 40000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_1m,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [3:0] ev_row,
    input  logic [2:0] ev_col,
    input  logic       ev_press,
    input  logic       ev_typed,
    input  logic       clear,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       busy,
    output logic [4:0] fifo_count
);

    localparam int          c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  c_DEPTH     = 5'(FIFO_DEPTH);
    localparam logic [16:0] c_HOLD_LOAD = 17'(HOLD_US - 1);
    localparam logic [16:0] c_GAP_LOAD  = 17'(GAP_US - 1);
    localparam logic [3:0]  c_ROWS      = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Queue entry layout: {typed, press, col[2:0], row[3:0]}
    logic [8:0]         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [4:0]         r_count;

    state_t             r_state;
    logic [16:0]        r_cnt;
    logic [9:0][7:0]    r_matrix;
    logic [3:0]         r_hold_row;
    logic [2:0]         r_hold_col;
    logic [7:0]         r_keyin;

    logic               w_push;
    logic               w_pop;
    logic [8:0]         w_head;
    logic [3:0]         w_head_row;
    logic [2:0]         w_head_col;
    logic               w_head_press;
    logic               w_head_typed;

    // Acceptance is refused during reset and clear so a flush never races a push.
    assign ev_ready     = reset_n & (r_count < c_DEPTH) & ~clear;
    assign w_push       = ev_valid & ev_ready;
    // The sequencer only drains the queue while idle, which preserves event order.
    assign w_pop        = (r_state == S_IDLE) & (r_count != 5'd0) & ~clear;

    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_row   = w_head[3:0];
    assign w_head_col   = w_head[6:4];
    assign w_head_press = w_head[7];
    assign w_head_typed = w_head[8];

    assign busy         = (r_count != 5'd0) | (r_state != S_IDLE);
    assign fifo_count   = r_count;
    assign keyin        = r_keyin;

    // Queue storage: written on accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {ev_typed, ev_press, ev_col, ev_row};
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + {4'd0, w_push} - {4'd0, w_pop};
        end
    end

    // Keystroke sequencer and key matrix update.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= 17'd0;
            r_matrix   <= '0;
            r_hold_row <= 4'd0;
            r_hold_col <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Rows 10..15 do not exist on the matrix: consume and drop.
                    if (w_pop && (w_head_row < c_ROWS)) begin
                        if (w_head_typed) begin
                            r_matrix[w_head_row][w_head_col] <= 1'b1;
                            r_hold_row                       <= w_head_row;
                            r_hold_col                       <= w_head_col;
                            r_cnt                            <= c_HOLD_LOAD;
                            r_state                          <= S_HOLD;
                        end else begin
                            r_matrix[w_head_row][w_head_col] <= w_head_press;
                        end
                    end
                end
                S_HOLD: begin
                    if (ce_1m) begin
                        if (r_cnt == 17'd0) begin
                            // Release unconditionally, even if a live press set it first.
                            r_matrix[r_hold_row][r_hold_col] <= 1'b0;
                            r_cnt                            <= c_GAP_LOAD;
                            r_state                          <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt - 17'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (ce_1m) begin
                        if (r_cnt == 17'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 17'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered row readout to the I/O block; nonexistent rows read all released.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_keyin <= 8'hFF;
        end else if (keyrow < c_ROWS) begin
            r_keyin <= ~r_matrix[keyrow];
        end else begin
            r_keyin <= 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pet_keymatrix.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pet_keymatrix
//  Description : Self-checking bench for pet_keymatrix with a queue-based
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pet_keymatrix;

    localparam int FD   = 8;
    localparam int HOLD = 4;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       reset_n, ce_1m, ev_valid, ev_press, ev_typed, clear;
    logic [3:0] ev_row, keyrow;
    logic [2:0] ev_col;
    logic       ev_ready, busy;
    logic [7:0] keyin;
    logic [4:0] fifo_count;

    always #5 clk = ~clk;

    pet_keymatrix #(.FIFO_DEPTH(FD), .HOLD_US(HOLD), .GAP_US(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_row(ev_row), .ev_col(ev_col), .ev_press(ev_press), .ev_typed(ev_typed),
        .clear(clear), .keyrow(keyrow), .keyin(keyin),
        .busy(busy), .fifo_count(fifo_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of pending events, a row array of pressed keys,
    // and a keystroke phase with the number of ce_1m ticks left in that phase.
    typedef struct packed {
        logic [3:0] row;
        logic [2:0] col;
        logic       press;
        logic       typed;
    } ev_t;

    ev_t        mq[$];
    logic [7:0] mmat [10];
    int         mphase;      // 0 = waiting for work, 1 = key held, 2 = gap
    int         mleft;
    int         mrow, mcol;
    logic [7:0] mkeyin;
    bit         accepted;

    function automatic bit m_ready();
        return (reset_n === 1'b1) && (mq.size() < FD) && (clear !== 1'b1);
    endfunction

    function automatic bit m_busy();
        return (mq.size() != 0) || (mphase != 0);
    endfunction

    // Advance model by one clock edge using the inputs currently driven, then
    // let the DUT take the same edge.
    task automatic step();
        logic [7:0] nk;
        bit         push;
        ev_t        e;
        push = ev_valid && m_ready();
        if (reset_n !== 1'b1) begin
            mq.delete();
            foreach (mmat[r]) mmat[r] = 8'h00;
            mphase = 0; mleft = 0; nk = 8'hFF; push = 0;
        end else if (clear === 1'b1) begin
            mq.delete();
            foreach (mmat[r]) mmat[r] = 8'h00;
            mphase = 0; mleft = 0; nk = 8'hFF;
        end else begin
            nk = (keyrow < 10) ? ~mmat[keyrow] : 8'hFF;
            if (mphase == 0 && mq.size() > 0) begin
                e = mq.pop_front();
                if (e.row < 10) begin
                    if (e.typed) begin
                        mmat[e.row][e.col] = 1'b1;
                        mrow = e.row; mcol = e.col;
                        mphase = 1; mleft = HOLD;
                    end else begin
                        mmat[e.row][e.col] = e.press;
                    end
                end
            end else if (mphase == 1 && ce_1m) begin
                mleft--;
                if (mleft == 0) begin
                    mmat[mrow][mcol] = 1'b0;
                    mphase = 2; mleft = GAP;
                end
            end else if (mphase == 2 && ce_1m) begin
                mleft--;
                if (mleft == 0) mphase = 0;
            end
            if (push) begin
                e.row = ev_row; e.col = ev_col; e.press = ev_press; e.typed = ev_typed;
                mq.push_back(e);
            end
        end
        accepted = push;
        @(posedge clk);
        #1;
        mkeyin = nk;
    endtask

    // Offer one event until it is taken, bounded.
    task automatic send(input int row, input int col, input bit press, input bit typed);
        int guard = 0;
        ev_valid = 1'b1; ev_row = row[3:0]; ev_col = col[2:0];
        ev_press = press; ev_typed = typed;
        accepted = 0;
        while (!accepted && guard < 200) begin
            step();
            guard++;
        end
        ev_valid = 1'b0;
        if (!accepted) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout row=%0d col=%0d got=not_accepted exp=accepted", row, col);
        end
    endtask

    task automatic flush();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL reset_keyin got=%h exp=ff", keyin); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (ev_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ev_ready); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (ev_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_release got=%b exp=1", ev_ready); end
        step();
    endtask

    task automatic test_live();
        bit seen = 0;
        ce_1m = 1'b0; keyrow = 4'd2;
        send(2, 5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (keyin === 8'hDF) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL live_press got=%h exp=df", keyin); end
        send(2, 5, 1'b0, 1'b0);
        repeat (3) step();
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL live_release got=%h exp=ff", keyin); end
    endtask

    task automatic test_typed();
        int held = 0, bticks = 0, guard = 0;
        ce_1m = 1'b0; keyrow = 4'd9;
        send(9, 0, 1'b0, 1'b1);
        while (keyin !== 8'hFE && guard < 10) begin step(); guard++; end
        n_cmp++; if (keyin !== 8'hFE) begin n_err++; $display("FAIL typed_press got=%h exp=fe", keyin); end
        for (int t = 0; t < 12; t++) begin
            step(); step();
            if (keyin === 8'hFE) held++;
            if (busy === 1'b1) bticks++;
            n_cmp++; if (keyin !== mkeyin) begin n_err++; $display("FAIL typed_model tick=%0d got=%h exp=%h", t, keyin, mkeyin); end
            ce_1m = 1'b1; step(); ce_1m = 1'b0;
        end
        n_cmp++; if (held != HOLD) begin n_err++; $display("FAIL typed_hold_ticks got=%0d exp=%0d", held, HOLD); end
        n_cmp++; if (bticks != HOLD + GAP) begin n_err++; $display("FAIL typed_busy_ticks got=%0d exp=%0d", bticks, HOLD + GAP); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL typed_busy_end got=%b exp=0", busy); end
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL typed_release got=%h exp=ff", keyin); end
    endtask

    task automatic test_fifo_full();
        flush(); ce_1m = 1'b0; keyrow = 4'd0;
        send(0, 0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < FD; i++) send(1, i, 1'b0, 1'b1);
        n_cmp++; if (fifo_count !== 5'(FD)) begin n_err++; $display("FAIL full_count got=%0d exp=%0d", fifo_count, FD); end
        n_cmp++; if (ev_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", ev_ready); end
        ev_valid = 1'b1; ev_row = 4'd5; ev_col = 3'd5; ev_typed = 1'b0; ev_press = 1'b1;
        step();
        ev_valid = 1'b0;
        n_cmp++; if (fifo_count !== 5'(mq.size())) begin n_err++; $display("FAIL full_reject got=%0d exp=%0d", fifo_count, mq.size()); end
        ce_1m = 1'b1; repeat (HOLD + GAP) step(); ce_1m = 1'b0;
        step();
        n_cmp++; if (fifo_count !== 5'(FD - 1)) begin n_err++; $display("FAIL full_drain_count got=%0d exp=%0d", fifo_count, FD - 1); end
        n_cmp++; if (ev_ready !== 1'b1) begin n_err++; $display("FAIL full_drain_ready got=%b exp=1", ev_ready); end
    endtask

    task automatic test_order();
        flush(); ce_1m = 1'b0; keyrow = 4'd3;
        send(3, 1, 1'b0, 1'b1);
        send(3, 1, 1'b0, 1'b0);
        send(3, 6, 1'b1, 1'b0);
        for (int t = 1; t <= HOLD + GAP; t++) begin
            ce_1m = 1'b1; step(); ce_1m = 1'b0;
            step(); step();
            n_cmp++; if (keyin !== mkeyin) begin n_err++; $display("FAIL order_model tick=%0d got=%h exp=%h", t, keyin, mkeyin); end
            if (t == HOLD - 1) begin
                n_cmp++; if (keyin !== 8'hFD) begin n_err++; $display("FAIL order_held got=%h exp=fd", keyin); end
            end
            if (t == HOLD) begin
                n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL order_hold_expiry got=%h exp=ff", keyin); end
                n_cmp++; if (fifo_count !== 5'd2) begin n_err++; $display("FAIL order_no_pop_in_gap got=%0d exp=2", fifo_count); end
            end
        end
        step();
        n_cmp++; if (keyin !== 8'hBF) begin n_err++; $display("FAIL order_after_gap got=%h exp=bf", keyin); end
    endtask

    task automatic test_clear();
        flush(); ce_1m = 1'b0; keyrow = 4'd4;
        send(4, 4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(i, 2, 1'b1, 1'b0);
        n_cmp++; if (fifo_count !== 5'd5) begin n_err++; $display("FAIL clear_pre_count got=%0d exp=5", fifo_count); end
        n_cmp++; if (keyin !== 8'hEF) begin n_err++; $display("FAIL clear_pre_keyin got=%h exp=ef", keyin); end
        clear = 1'b1; ev_valid = 1'b1; ev_row = 4'd1; ev_col = 3'd1; ev_typed = 1'b0; ev_press = 1'b1;
        #1;
        n_cmp++; if (ev_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready got=%b exp=0", ev_ready); end
        step();
        clear = 1'b0; ev_valid = 1'b0;
        n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL clear_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_busy got=%b exp=0", busy); end
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL clear_keyin got=%h exp=ff", keyin); end
        for (int r = 0; r < 16; r++) begin
            keyrow = 4'(r);
            step();
            n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL clear_row%0d got=%h exp=ff", r, keyin); end
        end
    endtask

    task automatic test_oob();
        flush(); ce_1m = 1'b0; keyrow = 4'd0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 8; c++)
                send(r, c, 1'b1, 1'b0);
        send(12, 3, 1'b1, 1'b0);
        send(11, 0, 1'b0, 1'b1);
        repeat (4) step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL oob_discard_busy got=%b exp=0", busy); end
        keyrow = 4'd12; step();
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL oob_row12 got=%h exp=ff", keyin); end
        keyrow = 4'd5; step();
        n_cmp++; if (keyin !== 8'h00) begin n_err++; $display("FAIL oob_row5_all got=%h exp=00", keyin); end
        keyrow = 4'd15; step();
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL oob_row15 got=%h exp=ff", keyin); end
    endtask

    task automatic test_reset_mid_gap();
        flush(); ce_1m = 1'b0; keyrow = 4'd1;
        send(1, 2, 1'b0, 1'b1);
        step();
        ce_1m = 1'b1; repeat (HOLD + 1) step(); ce_1m = 1'b0;
        send(6, 6, 1'b1, 1'b0); send(7, 7, 1'b1, 1'b0); send(8, 0, 1'b1, 1'b0);
        n_cmp++; if (fifo_count !== 5'd3) begin n_err++; $display("FAIL gap_queued got=%0d exp=3", fifo_count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy got=%b exp=1", busy); end
        reset_n = 1'b0; step();
        n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL gap_reset_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_reset_busy got=%b exp=0", busy); end
        n_cmp++; if (keyin !== 8'hFF) begin n_err++; $display("FAIL gap_reset_keyin got=%h exp=ff", keyin); end
        reset_n = 1'b1;
        ce_1m = 1'b1; repeat (6) step(); ce_1m = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_reset_idle got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 1500; i++) begin
            ev_valid = 1'($urandom_range(0, 1));
            ev_row   = 4'($urandom_range(0, 11));
            ev_col   = 3'($urandom_range(0, 7));
            ev_press = 1'($urandom_range(0, 1));
            ev_typed = ($urandom_range(0, 3) == 0);
            ce_1m    = ($urandom_range(0, 2) == 0);
            keyrow   = 4'($urandom_range(0, 15));
            clear    = ($urandom_range(0, 199) == 0);
            reset_n  = ($urandom_range(0, 399) != 0);
            #1;
            n_cmp++; if (ev_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, ev_ready, m_ready()); end
            step();
            n_cmp++; if (keyin !== mkeyin) begin n_err++; $display("FAIL rnd_keyin cyc=%0d got=%h exp=%h", i, keyin, mkeyin); end
            n_cmp++; if (busy !== m_busy()) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_busy()); end
            n_cmp++; if (fifo_count !== 5'(mq.size())) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, fifo_count, mq.size()); end
        end
        ev_valid = 1'b0; clear = 1'b0; reset_n = 1'b1; ce_1m = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ce_1m = 1'b0; ev_valid = 1'b0; ev_row = 4'd0; ev_col = 3'd0;
        ev_press = 1'b0; ev_typed = 1'b0; clear = 1'b0; keyrow = 4'd0;
        mphase = 0; mleft = 0; mrow = 0; mcol = 0; mkeyin = 8'hFF;
        foreach (mmat[r]) mmat[r] = 8'h00;
        test_reset();
        test_live();
        test_typed();
        test_fifo_full();
        test_order();
        test_clear();
        test_oob();
        test_reset_mid_gap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
